// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module   : uart_tx_frame
// Brief    : UART frame transmitter (start, LSB-first data, optional parity,
//            stop), one bit per clk cycle, with registered tx_out and busy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int               CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_tx    <= w_tx_next;
            r_busy  <= w_busy_next;
            if (w_accept) begin
                r_data    <= p_data;
                r_par_en  <= par_en;
                r_par_bit <= (^p_data) ^ par_typ;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_START;
                    w_cnt_next   = '0;
                end
            end
            S_START: begin
                w_state_next = S_DATA;
                w_cnt_next   = '0;
            end
            S_DATA: begin
                if (r_cnt == C_CNT_LAST) begin
                    w_state_next = r_par_en ? S_PARITY : S_STOP;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_PARITY: w_state_next = S_STOP;
            S_STOP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so the flops
        // present each bit in the same cycle the FSM occupies that slot.
        w_tx_next   = 1'b1;
        w_busy_next = 1'b1;
        case (w_state_next)
            S_IDLE:   w_busy_next = 1'b0;
            S_START:  w_tx_next   = 1'b0;
            S_DATA:   w_tx_next   = r_data[w_cnt_next];
            S_PARITY: w_tx_next   = r_par_bit;
            default:  w_tx_next   = 1'b1;
        endcase
    end

    assign tx_out = r_tx;
    assign busy   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// Module   : tb_uart_tx_frame
// Brief    : Cycle-accurate scoreboard bench for uart_tx_frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] p_data = '0;
    logic          data_valid = 1'b0;
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          tx_out;
    logic          busy;

    int n_total = 0;
    int n_bad   = 0;
    bit mon_en  = 1'b0;

    // Each entry is the expected {tx_out, busy} for one cycle.
    logic [1:0] exp_q[$];
    int         m_rem = 0;

    uart_tx_frame #(.DATA_WIDTH(DW)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic par_of(input logic [DW-1:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < DW; i++) if (d[i]) ones++;
        return logic'(ones % 2) ^ odd;
    endfunction

    // Reference model: accepts only when its own frame timer is idle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_rem <= 0;
        end else if (m_rem == 0) begin
            if (data_valid) begin
                exp_q.push_back(2'b01);
                for (int i = 0; i < DW; i++) exp_q.push_back({p_data[i], 1'b1});
                if (par_en) exp_q.push_back({par_of(p_data, par_typ), 1'b1});
                exp_q.push_back(2'b11);
                m_rem <= DW + 2 + (par_en ? 1 : 0);
            end
        end else begin
            m_rem <= m_rem - 1;
        end
    end

    always @(negedge clk) begin
        logic [1:0] e;
        if (mon_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b10;
            check("tx_out", {7'd0, tx_out}, {7'd0, e[1]});
            check("busy",   {7'd0, busy},   {7'd0, e[0]});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
        @(negedge clk);
        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_tx_async",   {7'd0, tx_out}, 8'd1);
        check("rst_busy_async", {7'd0, busy},   8'd0);
        mon_en = 1'b1;
        cycles(2);
        rst_n = 1'b1;
        cycles(5);

        send(8'hA5, 1'b0, 1'b0);
        cycles(13);
        send(8'hA5, 1'b1, 1'b0);
        cycles(13);
        send(8'hA5, 1'b1, 1'b1);
        cycles(13);
        send(8'h00, 1'b1, 1'b1);
        cycles(13);

        // Request and operand changes while a frame is in flight.
        send(8'h3C, 1'b1, 1'b0);
        cycles(3);
        p_data     = 8'hFF;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        cycles(1);
        data_valid = 1'b0;
        par_typ    = 1'b0;
        cycles(14);

        // Continuous request: frames separated by a single idle bit.
        p_data     = 8'h96;
        par_en     = 1'b1;
        par_typ    = 1'b1;
        data_valid = 1'b1;
        cycles(14);
        p_data     = 8'h5B;
        par_en     = 1'b0;
        cycles(20);
        data_valid = 1'b0;
        cycles(14);

        // Asynchronous reset in the 4th data bit.
        send(8'h3C, 1'b0, 1'b0);
        cycles(4);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx",   {7'd0, tx_out}, 8'd1);
        check("midrst_busy", {7'd0, busy},   8'd0);
        cycles(2);
        rst_n = 1'b1;
        cycles(3);
        send(8'h81, 1'b1, 1'b0);
        cycles(15);

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
